// File: rtl/turn_signal_ctrl.sv
// Tail-light front end: synchronises and debounces the hazard/left/right switches,
// decodes them into a pattern code, and divides the board clock into the LED step clock.
module turn_signal_ctrl #(
  parameter int unsigned DIV_COUNT       = 12_500_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       hazard_sw,
  input  logic       left_sw,
  input  logic       right_sw,
  output logic       clock_led,
  output logic [2:0] state_select,
  output logic       state_changed
);

  localparam int unsigned DIV_W = $clog2(DIV_COUNT);
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  localparam int HAZ = 2;
  localparam int LFT = 1;
  localparam int RGT = 0;

  typedef enum logic [2:0] {
    SEL_IDLE   = 3'b000,
    SEL_HAZARD = 3'b001,
    SEL_LEFT   = 3'b010,
    SEL_RIGHT  = 3'b011
  } sel_e;

  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            deb_q, deb_d;
  logic [2:0][DEB_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  led_q, led_d;
  sel_e                  sel_q, sel_d, req;
  logic                  changed_q, changed_d;
  logic                  toggle, fall;

  // NOTE: every variable gets its hold value first, so no path through the block
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DEB_W'(1);
      end
    end
  end

  // A left+right conflict is shown as hazard rather than picking a side.
  always_comb begin
    req = SEL_IDLE;
    if (deb_q[HAZ] || (deb_q[LFT] && deb_q[RGT])) req = SEL_HAZARD;
    else if (deb_q[LFT])                           req = SEL_LEFT;
    else if (deb_q[RGT])                           req = SEL_RIGHT;
  end

  always_comb begin
    toggle    = (div_cnt_q == DIV_LAST);
    fall      = toggle && led_q;
    div_cnt_d = toggle ? '0 : div_cnt_q + DIV_W'(1);
    led_d     = toggle ? ~led_q : led_q;
    // Only the falling toggle updates the code, keeping it stable around the consumer's rising edge.
    sel_d     = fall ? req : sel_q;
    changed_d = fall && (req != sel_q);
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      cnt_q     <= '0;
      div_cnt_q <= '0;
      led_q     <= 1'b0;
      sel_q     <= SEL_IDLE;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= {hazard_sw, left_sw, right_sw};
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      div_cnt_q <= div_cnt_d;
      led_q     <= led_d;
      sel_q     <= sel_d;
      changed_q <= changed_d;
    end
  end

  assign clock_led     = led_q;
  assign state_select  = sel_q;
  assign state_changed = changed_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Bench for turn_signal_ctrl: scenario tasks plus randomized switch activity, each
// compared cycle by cycle against a time-indexed behavioural model.
module tb_turn_signal_ctrl;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic       clock;
  logic       reset_n;
  logic       hazard_sw, left_sw, right_sw;
  logic       clock_led;
  logic [2:0] state_select;
  logic       state_changed;

  int checks;
  int errors;

  // Model: n counts rising edges since reset release; hist holds switch vectors
  // {hazard,left,right} as seen just before each edge.
  int         n;
  logic [2:0] hist[$];
  logic [2:0] m_deb;
  logic [2:0] m_state;
  logic       m_clk;
  logic       m_changed;
  logic       prev_led;
  logic [2:0] prev_state;

  turn_signal_ctrl #(.DIV_COUNT(DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .hazard_sw    (hazard_sw),
    .left_sw      (left_sw),
    .right_sw     (right_sw),
    .clock_led    (clock_led),
    .state_select (state_select),
    .state_changed(state_changed)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [2:0] decode(input logic [2:0] d);
    if (d[2] || (d[1] && d[0])) return 3'b001;
    if (d[1])                   return 3'b010;
    if (d[0])                   return 3'b011;
    return 3'b000;
  endfunction

  task automatic model_reset();
    n = 0;
    hist.delete();
    for (int i = 0; i < DEB + 2; i++) hist.push_back(3'b000);
    m_deb     = 3'b000;
    m_state   = 3'b000;
    m_clk     = 1'b0;
    m_changed = 1'b0;
  endtask

  // Step clock is a square wave of half-period DIV edges; the code is sampled from
  // the debounced switches every full period. A debounced bit flips once the last
  // DEB synchronised samples (switch delayed by two edges) all disagree with it.
  task automatic model_edge();
    int         last;
    logic [2:0] nxt;
    bit         all_diff;
    hist.push_back({hazard_sw, left_sw, right_sw});
    n++;
    if (n % (2 * DIV) == 0) begin
      nxt       = decode(m_deb);
      m_changed = (nxt != m_state);
      m_state   = nxt;
    end else begin
      m_changed = 1'b0;
    end
    m_clk = ((n / DIV) % 2) == 1;
    last = hist.size() - 1;
    for (int b = 0; b < 3; b++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++)
        if (hist[last - 2 - k][b] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) m_deb[b] = ~m_deb[b];
    end
    if (hist.size() > DEB + 4) void'(hist.pop_front());
  endtask

  // Called at a falling edge; returns at the next falling edge with the model advanced.
  task automatic tick();
    prev_led   = clock_led;
    prev_state = state_select;
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic do_reset(input string name);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({clock_led, state_select, state_changed} !== 5'b0) begin
      errors++;
      $display("FAIL %s_async_reset got %b expected 00000", name,
               {clock_led, state_select, state_changed});
    end
    model_reset();
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    {hazard_sw, left_sw, right_sw} = 3'b000;
    do_reset("reset");
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({clock_led, state_select, state_changed} !== {m_clk, m_state, m_changed}) begin
        errors++;
        $display("FAIL free_run n=%0d got %b expected %b", n,
                 {clock_led, state_select, state_changed}, {m_clk, m_state, m_changed});
      end
      if (n == 4 || n == 8) begin
        checks++;
        if (clock_led !== (n == 4)) begin
          errors++;
          $display("FAIL led_phase n=%0d got %b expected %b", n, clock_led, (n == 4));
        end
      end
    end
  endtask

  task automatic test_left();
    int pulses = 0;
    left_sw = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      pulses += state_changed;
      checks++;
      if ({clock_led, state_select, state_changed} !== {m_clk, m_state, m_changed}) begin
        errors++;
        $display("FAIL left n=%0d got %b expected %b", n,
                 {clock_led, state_select, state_changed}, {m_clk, m_state, m_changed});
      end
    end
    checks++;
    if (pulses !== 1 || state_select !== 3'b010) begin
      errors++;
      $display("FAIL left_pulse pulses=%0d sel=%b expected 1 and 010", pulses, state_select);
    end
    left_sw = 1'b0;
    for (int i = 0; i < 24; i++) tick();
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 36; i++) begin
      right_sw = (i < 20) && (i % 3 != 2);
      tick();
      checks++;
      if ({clock_led, state_select, state_changed} !== {m_clk, 3'b000, 1'b0}) begin
        errors++;
        $display("FAIL bounce n=%0d got %b expected %b", n,
                 {clock_led, state_select, state_changed}, {m_clk, 3'b000, 1'b0});
      end
    end
  endtask

  task automatic test_priority();
    int pulses = 0;
    {hazard_sw, left_sw, right_sw} = 3'b011;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if ({clock_led, state_select, state_changed} !== {m_clk, m_state, m_changed}) begin
        errors++;
        $display("FAIL prio_conflict n=%0d got %b expected %b", n,
                 {clock_led, state_select, state_changed}, {m_clk, m_state, m_changed});
      end
    end
    hazard_sw = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      pulses += state_changed;
    end
    checks++;
    if (pulses !== 0 || state_select !== 3'b001) begin
      errors++;
      $display("FAIL prio_hazard pulses=%0d sel=%b expected 0 and 001", pulses, state_select);
    end
    {hazard_sw, left_sw, right_sw} = 3'b000;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if ({clock_led, state_select, state_changed} !== {m_clk, m_state, m_changed}) begin
        errors++;
        $display("FAIL prio_drop n=%0d got %b expected %b", n,
                 {clock_led, state_select, state_changed}, {m_clk, m_state, m_changed});
      end
    end
    checks++;
    if (state_select !== 3'b000) begin
      errors++;
      $display("FAIL prio_idle got %b expected 000", state_select);
    end
  endtask

  task automatic test_edge();
    for (int i = 0; i < 8 && (n % 8) != 0; i++) tick();
    // Switch change here lands the debounced edge 5 edges later, mid high phase.
    hazard_sw = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if ((n % 8) == 0 && n > 0 && i < 8 &&
          (state_select !== 3'b001 || state_changed !== 1'b1 || prev_state !== 3'b000)) begin
        errors++;
        $display("FAIL edge_fall n=%0d got sel=%b chg=%b prev=%b expected 001 1 000", n,
                 state_select, state_changed, prev_state);
      end else if (!prev_led && clock_led && state_select !== prev_state) begin
        errors++;
        $display("FAIL edge_rise n=%0d got sel=%b expected %b", n, state_select, prev_state);
      end
    end
    hazard_sw = 1'b0;
    for (int i = 0; i < 24; i++) tick();
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 40; seg++) begin
      {hazard_sw, left_sw, right_sw} = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 20);
      for (int i = 0; i < hold; i++) begin
        tick();
        checks++;
        if ({clock_led, state_select, state_changed} !== {m_clk, m_state, m_changed}) begin
          errors++;
          $display("FAIL random n=%0d sw=%b got %b expected %b", n,
                   {hazard_sw, left_sw, right_sw},
                   {clock_led, state_select, state_changed}, {m_clk, m_state, m_changed});
        end
        checks++;
        if (!prev_led && clock_led && state_select !== prev_state) begin
          errors++;
          $display("FAIL random_rise n=%0d got %b expected %b", n, state_select, prev_state);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    {hazard_sw, left_sw, right_sw} = 3'b001;
    for (int i = 0; i < 40 && !(state_select === 3'b011 && clock_led === 1'b1); i++) tick();
    checks++;
    if (state_select !== 3'b011) begin
      errors++;
      $display("FAIL reset_mid_setup got %b expected 011", state_select);
    end
    do_reset("reset_mid");
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if ({clock_led, state_select, state_changed} !== {m_clk, m_state, m_changed}) begin
        errors++;
        $display("FAIL reset_mid n=%0d got %b expected %b", n,
                 {clock_led, state_select, state_changed}, {m_clk, m_state, m_changed});
      end
      if (n == 7 || n == 8) begin
        checks++;
        if (state_select !== ((n == 8) ? 3'b011 : 3'b000)) begin
          errors++;
          $display("FAIL reset_mid_return n=%0d got %b expected %b", n, state_select,
                   (n == 8) ? 3'b011 : 3'b000);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_left();
    test_bounce();
    test_priority();
    test_edge();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
